// File: rtl/loader_pkg.sv
// Shared types and width helpers for the burst data loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSN,
    S_DATA,
    S_DRAIN,
    S_DONE
  } loader_state_t;

  typedef enum logic {
    TAG_INSN = 1'b0,
    TAG_DATA = 1'b1
  } beat_tag_t;

  function automatic int wpb(input int bus_w);
    return bus_w / 32;
  endfunction

  function automatic int bcw(input int burst_max);
    return $clog2(burst_max) + 1;
  endfunction

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/loader_beat_fifo.sv
// Beat buffer: push-to-pop latency 1 cycle, head visible combinationally; no backpressure,
// the loader's credit accounting keeps pushes within DEPTH.
module loader_beat_fifo #(
  parameter int W      = 513,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic [W-1:0]    push_data,
  input  logic            pop,
  output logic [W-1:0]    pop_data,
  output logic            empty,
  output logic [CNTW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign do_push  = push && (count != CNTW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (do_push ? CNTW'(1) : '0) - (do_pop ? CNTW'(1) : '0);
    end
  end

endmodule

// File: rtl/burst_data_loader.sv
// Bursts an insn image then a data image from host memory into core init ports, one word per cycle.
// Requests throttle on FIFO credits; m0_waitrequest holds the pending request; writes never stall.
module burst_data_loader
  import loader_pkg::*;
#(
  parameter int CORES      = 4,
  parameter int INSN_DEPTH = 12,
  parameter int DMEM_DEPTH = 14,
  parameter int BUS_W      = 512,
  parameter int BURST_MAX  = 4,
  parameter int FIFO_BEATS = 8,
  localparam int CW        = idx_w(CORES),
  localparam int BCW       = bcw(BURST_MAX)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  kick,
  output logic                  busy,
  output logic                  done,
  input  logic [63:0]           memory_base_addr,
  input  logic [CW-1:0]         target_core,
  input  logic                  broadcast,
  input  logic [INSN_DEPTH:0]   insn_words,
  input  logic [DMEM_DEPTH:0]   data_words,
  output logic [INSN_DEPTH+1:0] insn_addr,
  output logic [31:0]           insn_dout,
  output logic [CORES-1:0]      insn_we,
  output logic [DMEM_DEPTH+1:0] data_addr,
  output logic [31:0]           data_dout,
  output logic [CORES-1:0]      data_we,
  output logic [63:0]           m0_address,
  output logic                  m0_read,
  output logic                  m0_write,
  output logic [BUS_W-1:0]      m0_writedata,
  output logic [BUS_W/8-1:0]    m0_byteenable,
  output logic [BCW-1:0]        m0_burstcount,
  input  logic                  m0_waitrequest,
  input  logic [BUS_W-1:0]      m0_readdata,
  input  logic                  m0_readdatavalid
);

  localparam int WPB        = wpb(BUS_W);
  localparam int WIW        = idx_w(WPB);
  localparam int OW         = $clog2(FIFO_BEATS) + 1;
  localparam int BEAT_BYTES = BUS_W / 8;
  localparam int PW         = ((INSN_DEPTH > DMEM_DEPTH) ? INSN_DEPTH : DMEM_DEPTH) + 1;

  loader_state_t       state;
  loader_state_t       state_nx;
  logic [INSN_DEPTH:0] insn_left;
  logic [DMEM_DEPTH:0] data_left;
  logic [INSN_DEPTH:0] rx_insn_left;
  logic [INSN_DEPTH:0] ilen;
  logic [DMEM_DEPTH:0] dlen;
  logic [CORES-1:0]    we_mask;
  logic [63:0]         next_addr;
  logic [OW-1:0]       outstanding;
  logic [OW-1:0]       credits;
  logic [PW-1:0]       phase_left;
  logic [BCW-1:0]      burst_n;
  logic                want;
  logic                issue;
  logic                start;
  logic [INSN_DEPTH:0] ib_calc;
  logic [DMEM_DEPTH:0] db_calc;

  logic                push;
  logic                pop;
  logic [BUS_W:0]      fifo_dout;
  logic                fifo_empty;
  logic [OW-1:0]       fifo_count;
  beat_tag_t           push_tag;

  logic [BUS_W-1:0]    beat_sr;
  beat_tag_t           cur_tag;
  logic [WIW-1:0]      widx;
  logic                active;
  logic [INSN_DEPTH:0] iwc;
  logic [DMEM_DEPTH:0] dwc;
  logic                len_hit;
  logic                word_last;

  assign busy          = (state != S_IDLE) | kick;
  assign m0_write      = 1'b0;
  assign m0_writedata  = '0;
  assign m0_byteenable = '1;

  assign start   = (state == S_IDLE) && kick;
  assign ib_calc = (INSN_DEPTH+1)'((32'(insn_words) + 32'(WPB - 1)) / 32'(WPB));
  assign db_calc = (DMEM_DEPTH+1)'((32'(data_words) + 32'(WPB - 1)) / 32'(WPB));

  always_comb begin
    state_nx   = state;
    phase_left = '0;
    want       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (kick) begin
          if (ib_calc != '0)      state_nx = S_INSN;
          else if (db_calc != '0) state_nx = S_DATA;
          else                    state_nx = S_DONE;
        end
      end
      S_INSN: begin
        phase_left = PW'(insn_left);
        want       = (insn_left != '0);
        if (insn_left == '0) state_nx = (data_left != '0) ? S_DATA : S_DRAIN;
      end
      S_DATA: begin
        phase_left = PW'(data_left);
        want       = (data_left != '0);
        if (data_left == '0) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty && (outstanding == '0) && !active && !m0_read) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outstanding counts beats from the moment a burst is presented, so credits never overcommit.
  assign burst_n = (phase_left >= PW'(BURST_MAX)) ? BCW'(BURST_MAX) : BCW'(phase_left);
  assign credits = OW'(FIFO_BEATS) - fifo_count - outstanding;
  assign issue   = want && (!m0_read || !m0_waitrequest) && (credits >= OW'(burst_n));

  assign push     = m0_readdatavalid && (outstanding != '0);
  assign push_tag = (rx_insn_left != '0) ? TAG_INSN : TAG_DATA;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      done          <= 1'b0;
      insn_left     <= '0;
      data_left     <= '0;
      rx_insn_left  <= '0;
      ilen          <= '0;
      dlen          <= '0;
      we_mask       <= '0;
      next_addr     <= '0;
      outstanding   <= '0;
      m0_read       <= 1'b0;
      m0_address    <= '0;
      m0_burstcount <= BCW'(1);
    end else begin
      state <= state_nx;
      done  <= (state == S_DONE);
      if (start) begin
        insn_left    <= ib_calc;
        data_left    <= db_calc;
        rx_insn_left <= ib_calc;
        ilen         <= insn_words;
        dlen         <= data_words;
        we_mask      <= broadcast ? '1 : (CORES'(1) << target_core);
        next_addr    <= memory_base_addr;
      end
      if (issue) begin
        m0_read       <= 1'b1;
        m0_address    <= next_addr;
        m0_burstcount <= burst_n;
        next_addr     <= next_addr + 64'(burst_n) * 64'(BEAT_BYTES);
        if (state == S_INSN) insn_left <= insn_left - (INSN_DEPTH+1)'(burst_n);
        else                 data_left <= data_left - (DMEM_DEPTH+1)'(burst_n);
      end else if (!m0_waitrequest) begin
        m0_read <= 1'b0;
      end
      outstanding <= outstanding + (issue ? OW'(burst_n) : '0) - (push ? OW'(1) : '0);
      if (push && (rx_insn_left != '0)) rx_insn_left <= rx_insn_left - (INSN_DEPTH+1)'(1);
    end
  end

  loader_beat_fifo #(
    .W     (BUS_W + 1),
    .DEPTH (FIFO_BEATS)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({push_tag, m0_readdata}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A beat ends at its last word or at the image's last word, whichever comes first.
  always_comb begin
    if (cur_tag == TAG_INSN) len_hit = ((iwc + (INSN_DEPTH+1)'(1)) == ilen);
    else                     len_hit = ((dwc + (DMEM_DEPTH+1)'(1)) == dlen);
    word_last = active && ((widx == WIW'(WPB - 1)) || len_hit);
  end

  assign pop = !fifo_empty && (!active || word_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_sr   <= '0;
      cur_tag   <= TAG_INSN;
      widx      <= '0;
      active    <= 1'b0;
      iwc       <= '0;
      dwc       <= '0;
      insn_we   <= '0;
      insn_addr <= '0;
      insn_dout <= '0;
      data_we   <= '0;
      data_addr <= '0;
      data_dout <= '0;
    end else begin
      insn_we <= '0;
      data_we <= '0;
      if (start) begin
        iwc <= '0;
        dwc <= '0;
      end
      if (active) begin
        if (cur_tag == TAG_INSN) begin
          insn_we   <= we_mask;
          insn_addr <= (INSN_DEPTH+2)'({iwc, 2'b00});
          insn_dout <= beat_sr[31:0];
          iwc       <= iwc + (INSN_DEPTH+1)'(1);
        end else begin
          data_we   <= we_mask;
          data_addr <= (DMEM_DEPTH+2)'({dwc, 2'b00});
          data_dout <= beat_sr[31:0];
          dwc       <= dwc + (DMEM_DEPTH+1)'(1);
        end
        beat_sr <= beat_sr >> 32;
        widx    <= widx + WIW'(1);
      end
      if (pop) begin
        beat_sr <= fifo_dout[BUS_W-1:0];
        cur_tag <= beat_tag_t'(fifo_dout[BUS_W]);
        widx    <= '0;
        active  <= 1'b1;
      end else if (word_last) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_burst_data_loader.sv
// Randomised bench: Avalon slave over a hashed memory image, expected writes/requests from plain arithmetic.
`timescale 1ns/1ps
module tb_burst_data_loader;

  localparam int CORES = 4, INSN_DEPTH = 12, DMEM_DEPTH = 14;
  localparam int BUS_W = 512, BURST_MAX = 4, FIFO_BEATS = 8;
  localparam int WPB = BUS_W / 32, BB = BUS_W / 8;

  logic clk = 1'b0, reset_n = 1'b0, kick = 1'b0, busy, done, broadcast = 1'b0;
  logic [63:0] memory_base_addr = '0;
  logic [1:0]  target_core = '0;
  logic [INSN_DEPTH:0] insn_words = '0;
  logic [DMEM_DEPTH:0] data_words = '0;
  logic [INSN_DEPTH+1:0] insn_addr;
  logic [DMEM_DEPTH+1:0] data_addr;
  logic [31:0] insn_dout, data_dout;
  logic [CORES-1:0] insn_we, data_we;
  logic [63:0] m0_address;
  logic m0_read, m0_write, m0_waitrequest = 1'b0, m0_readdatavalid = 1'b0;
  logic [BUS_W-1:0] m0_writedata, m0_readdata = '0;
  logic [BUS_W/8-1:0] m0_byteenable;
  logic [2:0] m0_burstcount;

  burst_data_loader #(
    .CORES(CORES), .INSN_DEPTH(INSN_DEPTH), .DMEM_DEPTH(DMEM_DEPTH),
    .BUS_W(BUS_W), .BURST_MAX(BURST_MAX), .FIFO_BEATS(FIFO_BEATS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .kick(kick), .busy(busy), .done(done),
    .memory_base_addr(memory_base_addr), .target_core(target_core), .broadcast(broadcast),
    .insn_words(insn_words), .data_words(data_words),
    .insn_addr(insn_addr), .insn_dout(insn_dout), .insn_we(insn_we),
    .data_addr(data_addr), .data_dout(data_dout), .data_we(data_we),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_burstcount(m0_burstcount),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0, err_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host memory: every 32-bit word is a hash of its byte address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = a[33:2] ^ a[63:32];
    return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  logic [63:0] beat_q[$];
  logic [49:0] exp_insn_q[$];
  logic [51:0] exp_data_q[$];
  logic [71:0] exp_req_q[$];
  bit flush = 1'b0, rand_mode = 1'b0;
  int rd_cycles = 0, done_cnt = 0, done_cyc = 0, kick_cyc = 0, max_q = 0;
  int insn_wr_cnt = 0, data_wr_cnt = 0;

  // Slave drive: new waitrequest and at most one response beat per cycle.
  initial begin
    logic [63:0] a;
    forever begin
      @(posedge clk); #1;
      if (flush) begin
        beat_q.delete();
        m0_readdatavalid = 1'b0;
        m0_waitrequest   = 1'b0;
      end else begin
        m0_waitrequest = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (beat_q.size() > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) begin
          a = beat_q.pop_front();
          for (int k = 0; k < WPB; k++) m0_readdata[k*32 +: 32] = mem_word(a + 64'(k * 4));
          m0_readdatavalid = 1'b1;
        end else begin
          m0_readdatavalid = 1'b0;
        end
      end
    end
  end

  // Observation on the falling edge.
  initial begin
    bit stalled_prev;
    logic [71:0] held;
    stalled_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stalled_prev = 1'b0;
        continue;
      end
      if (stalled_prev)
        chk("req_hold", 128'({m0_read, m0_address, 8'(m0_burstcount)}), 128'({1'b1, held}));
      if (m0_read) rd_cycles++;
      if (m0_read && !m0_waitrequest) begin
        if (exp_req_q.size() > 0)
          chk("req", 128'({m0_address, 8'(m0_burstcount)}), 128'(exp_req_q.pop_front()));
        else
          chk("req_unexp", 128'(m0_read), 128'(0));
        for (int k = 0; k < int'(m0_burstcount); k++) beat_q.push_back(m0_address + 64'(k * BB));
        if (beat_q.size() > max_q) max_q = beat_q.size();
      end
      stalled_prev = m0_read && m0_waitrequest;
      held = {m0_address, 8'(m0_burstcount)};
      if (insn_we != '0) begin
        insn_wr_cnt++;
        if (exp_insn_q.size() > 0)
          chk("insn_wr", 128'({insn_we, insn_addr, insn_dout}), 128'(exp_insn_q.pop_front()));
        else
          chk("insn_unexp", 128'(insn_we), 128'(0));
      end
      if (data_we != '0) begin
        data_wr_cnt++;
        if (exp_data_q.size() > 0)
          chk("data_wr", 128'({data_we, data_addr, data_dout}), 128'(exp_data_q.pop_front()));
        else
          chk("data_unexp", 128'(data_we), 128'(0));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", 128'(busy), 128'(0));
      end
    end
  end

  int ld_iw, ld_dw, ld_d0, ld_i0, ld_w0, ld_r0;

  task automatic start_load(input logic [63:0] base, input int iw, input int dw,
                            input int core, input bit bc, input bit rnd);
    int ib, db, left, n;
    logic [63:0] a;
    logic [3:0] mask;
    ib = (iw + WPB - 1) / WPB;
    db = (dw + WPB - 1) / WPB;
    mask = bc ? 4'hF : 4'(1 << core);
    exp_insn_q.delete(); exp_data_q.delete(); exp_req_q.delete();
    for (int i = 0; i < iw; i++)
      exp_insn_q.push_back({mask, 14'(i * 4), mem_word(base + 64'(i * 4))});
    for (int j = 0; j < dw; j++)
      exp_data_q.push_back({mask, 16'(j * 4), mem_word(base + 64'(ib * BB) + 64'(j * 4))});
    a = base;
    for (int ph = 0; ph < 2; ph++) begin
      left = (ph == 0) ? ib : db;
      while (left > 0) begin
        n = (left > BURST_MAX) ? BURST_MAX : left;
        exp_req_q.push_back({a, 8'(n)});
        a += 64'(n * BB);
        left -= n;
      end
    end
    rand_mode = rnd;
    max_q = 0;
    ld_iw = iw; ld_dw = dw;
    ld_d0 = done_cnt; ld_i0 = insn_wr_cnt; ld_w0 = data_wr_cnt; ld_r0 = rd_cycles;
    @(posedge clk); #1;
    memory_base_addr = base;
    insn_words = (INSN_DEPTH+1)'(iw);
    data_words = (DMEM_DEPTH+1)'(dw);
    target_core = 2'(core);
    broadcast = bc;
    kick = 1'b1;
    kick_cyc = cyc;
    #1 chk("busy_on_kick", 128'(busy), 128'(1));
    @(posedge clk); #1;
    kick = 1'b0;
    memory_base_addr = {$urandom, $urandom};
    insn_words = '1;
    data_words = '1;
    target_core = 2'(~core);
    broadcast = ~bc;
  endtask

  task automatic finish_load(input string nm);
    int limit;
    limit = cyc + 4 * (ld_iw + ld_dw) + 500;
    while (done_cnt == ld_d0 && cyc < limit) @(posedge clk);
    chk({nm, "_reached_done"}, 128'(done_cnt != ld_d0), 128'(1));
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_done_pulses"}, 128'(done_cnt - ld_d0), 128'(1));
    chk({nm, "_insn_writes"}, 128'(insn_wr_cnt - ld_i0), 128'(ld_iw));
    chk({nm, "_data_writes"}, 128'(data_wr_cnt - ld_w0), 128'(ld_dw));
    chk({nm, "_reqs_left"}, 128'(exp_req_q.size()), 128'(0));
    chk({nm, "_inflight_ok"}, 128'(max_q <= FIFO_BEATS), 128'(1));
    chk({nm, "_busy_after"}, 128'(busy), 128'(0));
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_insn_we"}, 128'(insn_we), 128'(0));
    chk({nm, "_data_we"}, 128'(data_we), 128'(0));
    chk({nm, "_insn_addr"}, 128'(insn_addr), 128'(0));
    chk({nm, "_data_dout"}, 128'(data_dout), 128'(0));
    chk({nm, "_m0_read"}, 128'(m0_read), 128'(0));
    chk({nm, "_m0_addr"}, 128'(m0_address), 128'(0));
    chk({nm, "_m0_bc"}, 128'(m0_burstcount), 128'(1));
    chk({nm, "_m0_be"}, 128'(m0_byteenable), {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    chk({nm, "_done"}, 128'(done), 128'(0));
    chk({nm, "_busy"}, 128'(busy), 128'(0));
  endtask

  function automatic logic [63:0] rand_base();
    return {$urandom, $urandom} & ~64'h3F;
  endfunction

  initial begin
    #23;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    start_load(64'h0000_1000, 16, 16, 2, 1'b0, 1'b0);
    finish_load("basic");

    start_load(64'h0000_0000_0002_0000, 70, 0, 1, 1'b0, 1'b0);
    finish_load("insn70");

    start_load(rand_base(), 40, 100, $urandom_range(0, 3), 1'b1, 1'b1);
    finish_load("bcast");

    start_load(rand_base(), 0, 0, 3, 1'b0, 1'b1);
    finish_load("zero");
    chk("zero_done_latency", 128'(done_cyc - kick_cyc), 128'(2));
    chk("zero_no_read", 128'(rd_cycles - ld_r0), 128'(0));

    for (int r = 0; r < 4; r++) begin
      start_load(rand_base(), $urandom_range(0, 300), $urandom_range(0, 300),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
      finish_load("rand");
    end

    start_load(rand_base(), 1 << INSN_DEPTH, 1 << DMEM_DEPTH, 1, 1'b0, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    kick = 1'b1;
    @(posedge clk); #1;
    kick = 1'b0;
    finish_load("full");

    start_load(rand_base(), 2000, 3000, 0, 1'b0, 1'b1);
    repeat (60) @(posedge clk);
    #2;
    reset_n = 1'b0;
    flush = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_insn_q.delete(); exp_data_q.delete(); exp_req_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    start_load(rand_base(), 123, 77, 3, 1'b0, 1'b1);
    finish_load("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
